cl_mem_ctrl: RTL and testbench
==============================

Name: cl_mem_ctrl

Overview:
Parametrised load/store sequencer for the core's memory stage, the next step beyond pure decode of memory-op classes. It takes pre-decoded memory ops (load/store, byte/half/word/dword, signed/unsigned) and drives a valid/ready request and valid-only response interface to data memory. It generates byte enables, aligns store data, and extracts and extends load data. It also stalls the pipeline, handles flush and timeout, and flags misaligned accesses.

Parameters:
DATA_W, 32, memory data width in bits; 32 or 64
ADDR_W, 32, byte address width
RD_W, 5, destination register index width
TIMEOUT_CYC, 64, cycles in REQ+RESP before timeout error; 0 disables the timeout

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
op_valid_i  in  1  memory-stage op valid; held stable by the pipeline while stall_o=1
op_load_i  in  1  op is a load
op_store_i  in  1  op is a store; load and store never both 1
op_size_i  in  2  access size: 0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64)
op_signed_i  in  1  load extension: 1=sign-extend, 0=zero-extend
op_addr_i  in  ADDR_W  byte address
op_wdata_i  in  DATA_W  store data, least-significant-aligned
op_rd_i  in  RD_W  load destination register
flush_i  in  1  abort the current op
stall_o  out  1  hold the memory stage
mem_req_valid_o  out  1  request valid
mem_req_ready_i  in  1  memory accepts the request
mem_req_we_o  out  1  1=write
mem_req_addr_o  out  ADDR_W  address aligned to DATA_W/8 (low bits zeroed)
mem_req_be_o  out  DATA_W/8  byte-lane enables
mem_req_wdata_o  out  DATA_W  store data replicated across lanes
mem_rsp_valid_i  in  1  read data valid (loads only)
mem_rsp_data_i  in  DATA_W  read data
wb_valid_o  out  1  load result valid, 1-cycle pulse
wb_rd_o  out  RD_W  load destination
wb_data_o  out  DATA_W  extended load result
err_o  out  1  error pulse
err_code_o  out  2  1=misaligned/illegal size, 2=timeout

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, timeout counter=0. All registered outputs, err_code_o and wb_data_o are 0. Responses arriving after reset are ignored.
- States are IDLE, REQ, RESP, DONE and DRAIN. Request fields are registered at accept and stay stable through REQ.
- IDLE, legal mem op valid: latch the op and go to REQ. stall_o=1 combinationally in that same cycle.
- IDLE, illegal op: an op is illegal if size is misaligned (half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0) or size=3 with DATA_W=32. In the same cycle: err_o=1, err_code_o=1, stall_o=0, no request issued. Stay in IDLE.
- REQ: mem_req_valid_o=1.
  - Store handshake goes to DONE.
  - Load handshake goes to RESP.
  - flush_i before the handshake goes to IDLE with no error.
  - If flush_i and mem_req_ready_i are both 1 in the same cycle, the handshake completes. A store goes to IDLE (the write still happens). A load goes to DRAIN.
- RESP: on mem_rsp_valid_i, capture the extended data and go to DONE. flush_i goes to DRAIN.
- DRAIN: wait for mem_rsp_valid_i, discard it, go to IDLE. stall_o=1. No wb_valid_o. The timeout also applies in DRAIN and returns to IDLE.
- DONE (1 cycle): stall_o=0 and wb_valid_o=1 for loads. Go to IDLE. Minimum latency is 3 cycles for a store and 4 for a load with a 1-cycle response.
- Timeout: the counter increments in REQ/RESP/DRAIN and clears in IDLE. When count==TIMEOUT_CYC-1 and no handshake or response occurs that cycle: err_o=1, err_code_o=2, then go to DONE with wb_valid_o suppressed.
- Byte enables: with lane = addr[log2(DATA_W/8)-1:0], be = ((1<<(1<<size))-1) << lane.
- Load extraction: shift the response right by 8*lane, mask to 8<<size bits, then sign- or zero-extend to DATA_W. A full-width load is unchanged.
- flush_i in IDLE or DONE has no effect.

Decomposition:
- Shared definitions package holds:
  - the size encoding (kSizeByte/Half/Word/Dword);
  - the err_code encoding;
  - the state enum.
- One natural sub-module, cl_mem_align, is purely combinational and contains:
  - the misalignment check;
  - byte-enable generation;
  - write-data replication;
  - load extraction and extension.

Test Plan:
- Load byte signed, addr=0x1003, rsp=0x80FF_FF12 (1-cycle rsp) -> be=4'b1000; wb_data=0xFFFF_FF80 in the DONE cycle, 4 cycles after accept.
- Store half, addr=0x2002, wdata=0x0000_BEEF, ready held 0 for 3 cycles -> valid held 4 cycles; be=4'b1100, wdata=0xBEEF_BEEF, addr=0x2000; stall deasserts in DONE.
- Load word, addr=0x3001 -> err_o=1, code=1 in the same cycle; no mem_req_valid_o; stall_o=0.
- Load word issued, flush_i in the RESP cycle, rsp arrives 2 cycles later -> DRAIN; no wb_valid_o; next op accepted after the response.
- TIMEOUT_CYC=8, ready never asserted -> err_o with code=2 at the 8th REQ cycle; DONE, then IDLE; no write.
- reset_n=0 mid-RESP, then a stray rsp -> outputs 0, IDLE, rsp ignored; DATA_W=64 dword load at addr 0x8 gives be=8'hFF.

Source files
------------

// File: rtl/cl_mem_ctrl_pkg.sv
// Shared definitions for the memory-stage load/store sequencer.
//   - access size encoding carried on op_size_i
//   - error code encoding driven on err_code_o
//   - sequencer state enumeration
package cl_mem_ctrl_pkg;

    localparam logic [1:0] kSizeByte  = 2'd0;
    localparam logic [1:0] kSizeHalf  = 2'd1;
    localparam logic [1:0] kSizeWord  = 2'd2;
    localparam logic [1:0] kSizeDword = 2'd3;

    localparam logic [1:0] kErrNone    = 2'd0;
    localparam logic [1:0] kErrAlign   = 2'd1;
    localparam logic [1:0] kErrTimeout = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/cl_mem_align.sv
// Combinational lane logic for the load/store sequencer.
// Ports:
//   req_size_i/req_addr_lo_i/req_wdata_i : incoming op size, low address bits, raw store data
//   req_illegal_o                        : misaligned access or size not supported by the bus
//   req_be_o/req_wdata_o                 : byte enables and lane-replicated store data
//   ld_size_i/ld_lane_i/ld_signed_i      : latched load shape
//   ld_rsp_i/ld_data_o                   : raw bus word in, extracted and extended result out
module cl_mem_align
    import cl_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        req_size_i,
    input  logic [2:0]        req_addr_lo_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_illegal_o,
    output logic [BE_W-1:0]   req_be_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic [1:0]        ld_size_i,
    input  logic [LANE_W-1:0] ld_lane_i,
    input  logic              ld_signed_i,
    input  logic [DATA_W-1:0] ld_rsp_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [2:0]        align_mask;
    logic [BE_W-1:0]   be_base;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_mask;
    logic              ld_msb;

    always_comb begin
        align_mask  = 3'b000;
        be_base     = BE_W'(1);
        req_wdata_o = {BE_W{req_wdata_i[7:0]}};
        case (req_size_i)
            kSizeByte: ;
            kSizeHalf: begin
                align_mask  = 3'b001;
                be_base     = BE_W'(4'h3);
                req_wdata_o = {(DATA_W / 16){req_wdata_i[15:0]}};
            end
            kSizeWord: begin
                align_mask  = 3'b011;
                be_base     = BE_W'(4'hF);
                req_wdata_o = {(DATA_W / 32){req_wdata_i[31:0]}};
            end
            default: begin
                align_mask  = 3'b111;
                be_base     = '1;
                req_wdata_o = req_wdata_i;
            end
        endcase
        // A dword on a 32-bit bus cannot be expressed as a single beat.
        req_illegal_o = (|(req_addr_lo_i & align_mask)) ||
                        ((req_size_i == kSizeDword) && (DATA_W == 32));
        req_be_o = be_base << req_addr_lo_i[LANE_W-1:0];
    end

    always_comb begin
        ld_shift = ld_rsp_i >> {ld_lane_i, 3'b000};
        ld_mask  = DATA_W'(8'hFF);
        ld_msb   = ld_shift[7];
        case (ld_size_i)
            kSizeByte: ;
            kSizeHalf: begin
                ld_mask = DATA_W'(16'hFFFF);
                ld_msb  = ld_shift[15];
            end
            kSizeWord: begin
                ld_mask = DATA_W'(32'hFFFF_FFFF);
                ld_msb  = ld_shift[31];
            end
            default: begin
                ld_mask = '1;
                ld_msb  = ld_shift[DATA_W-1];
            end
        endcase
        // Extension fills exactly the bits the mask removed; a full-width load has none.
        ld_data_o = (ld_shift & ld_mask) | ((ld_signed_i && ld_msb) ? ~ld_mask : '0);
    end

endmodule

// File: rtl/cl_mem_ctrl.sv
// Memory-stage load/store sequencer: accepts one pre-decoded op at a time,
// issues a valid/ready request, collects the load response and writes back.
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   op_*_i, flush_i, stall_o          : pipeline side
//   mem_req_*                         : request channel (valid/ready)
//   mem_rsp_*                         : response channel (valid only, loads)
//   wb_*_o                            : load writeback
//   err_o, err_code_o                 : error pulse and cause
//
// state    | meaning
// ST_IDLE  | waiting for an op; illegal ops are flagged here and dropped
// ST_REQ   | request valid, waiting for ready
// ST_RESP  | load issued, waiting for read data
// ST_DONE  | one-cycle completion, writeback pulse for loads
// ST_DRAIN | flushed load, swallowing its response
module cl_mem_ctrl
    import cl_mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int RD_W        = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                op_valid_i,
    input  logic                op_load_i,
    input  logic                op_store_i,
    input  logic [1:0]          op_size_i,
    input  logic                op_signed_i,
    input  logic [ADDR_W-1:0]   op_addr_i,
    input  logic [DATA_W-1:0]   op_wdata_i,
    input  logic [RD_W-1:0]     op_rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_we_o,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic [DATA_W/8-1:0] mem_req_be_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,
    output logic                wb_valid_o,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic                err_o,
    output logic [1:0]          err_code_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                we_q, signed_q, tout_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q, wb_data_q;
    logic [RD_W-1:0]     rd_q;

    logic                accept, capture, set_tout, tout_hit, op_illegal;
    logic [BE_W-1:0]     be_w;
    logic [DATA_W-1:0]   wdata_w, ld_data_w;

    cl_mem_align #(.DATA_W(DATA_W)) u_align (
        .req_size_i    (op_size_i),
        .req_addr_lo_i (op_addr_i[2:0]),
        .req_wdata_i   (op_wdata_i),
        .req_illegal_o (op_illegal),
        .req_be_o      (be_w),
        .req_wdata_o   (wdata_w),
        .ld_size_i     (size_q),
        .ld_lane_i     (addr_q[LANE_W-1:0]),
        .ld_signed_i   (signed_q),
        .ld_rsp_i      (mem_rsp_data_i),
        .ld_data_o     (ld_data_w)
    );

    // Saturating at the terminal count keeps the timeout armed even when a
    // handshake lands exactly on the last REQ cycle and RESP follows.
    assign cnt_inc  = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
    assign tout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_o    = 1'b0;
        err_o      = 1'b0;
        err_code_o = kErrNone;
        accept     = 1'b0;
        capture    = 1'b0;
        set_tout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (op_valid_i && (op_load_i || op_store_i)) begin
                    if (op_illegal) begin
                        err_o      = 1'b1;
                        err_code_o = kErrAlign;
                    end else begin
                        accept  = 1'b1;
                        stall_o = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_req_ready_i) begin
                    // A flushed store still writes; a flushed load must swallow its response.
                    if (flush_i) state_d = we_q ? ST_IDLE : ST_DRAIN;
                    else         state_d = we_q ? ST_DONE : ST_RESP;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (tout_hit) begin
                    err_o      = 1'b1;
                    err_code_o = kErrTimeout;
                    set_tout   = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_RESP: begin
                stall_o = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_rsp_valid_i) begin
                    // Response and flush together: the data is consumed and dropped.
                    capture = !flush_i;
                    state_d = flush_i ? ST_IDLE : ST_DONE;
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else if (tout_hit) begin
                    err_o      = 1'b1;
                    err_code_o = kErrTimeout;
                    set_tout   = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DRAIN: begin
                stall_o = 1'b1;
                cnt_d   = cnt_inc;
                if (mem_rsp_valid_i) begin
                    state_d = ST_IDLE;
                end else if (tout_hit) begin
                    err_o      = 1'b1;
                    err_code_o = kErrTimeout;
                    state_d    = ST_IDLE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            tout_q    <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= op_store_i;
                signed_q <= op_signed_i;
                size_q   <= op_size_i;
                addr_q   <= op_addr_i;
                be_q     <= be_w;
                wdata_q  <= wdata_w;
                rd_q     <= op_rd_i;
                tout_q   <= 1'b0;
            end
            if (set_tout) tout_q <= 1'b1;
            if (capture) wb_data_q <= ld_data_w;
        end
    end

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = {addr_q[ADDR_W-1:LANE_W], LANE_W'(0)};
    assign mem_req_be_o    = be_q;
    assign mem_req_wdata_o = wdata_q;
    assign wb_valid_o      = (state_q == ST_DONE) && !we_q && !tout_q;
    assign wb_rd_o         = rd_q;
    assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_cl_mem_ctrl.sv
// Bench for cl_mem_ctrl: a 32-bit instance with a short timeout and a 64-bit
// instance, checked against a byte-level reference model of the bus rules.
module tb_cl_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        reset_n, reset64_n;
    logic        op_valid, op_load, op_store, op_signed, flush, req_ready, rsp_valid;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [63:0] op_wdata, rsp_data;
    logic [4:0]  op_rd;

    logic        stall, req_valid, req_we, wb_valid, err;
    logic [31:0] req_addr, req_wdata, wb_data;
    logic [3:0]  req_be;
    logic [4:0]  wb_rd;
    logic [1:0]  err_code;

    logic        s_stall, s_req_valid, s_req_we, s_wb_valid, s_err;
    logic [31:0] s_req_addr;
    logic [7:0]  s_req_be;
    logic [63:0] s_req_wdata, s_wb_data;
    logic [4:0]  s_wb_rd;
    logic [1:0]  s_err_code;

    cl_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_W(5), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .op_valid_i(op_valid), .op_load_i(op_load), .op_store_i(op_store),
        .op_size_i(op_size), .op_signed_i(op_signed), .op_addr_i(op_addr),
        .op_wdata_i(op_wdata[31:0]), .op_rd_i(op_rd), .flush_i(flush), .stall_o(stall),
        .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready), .mem_req_we_o(req_we),
        .mem_req_addr_o(req_addr), .mem_req_be_o(req_be), .mem_req_wdata_o(req_wdata),
        .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data[31:0]),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .err_o(err), .err_code_o(err_code)
    );

    cl_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .RD_W(5), .TIMEOUT_CYC(64)) dut64 (
        .clk(clk), .reset_n(reset64_n),
        .op_valid_i(op_valid), .op_load_i(op_load), .op_store_i(op_store),
        .op_size_i(op_size), .op_signed_i(op_signed), .op_addr_i(op_addr),
        .op_wdata_i(op_wdata), .op_rd_i(op_rd), .flush_i(flush), .stall_o(s_stall),
        .mem_req_valid_o(s_req_valid), .mem_req_ready_i(req_ready), .mem_req_we_o(s_req_we),
        .mem_req_addr_o(s_req_addr), .mem_req_be_o(s_req_be), .mem_req_wdata_o(s_req_wdata),
        .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data),
        .wb_valid_o(s_wb_valid), .wb_rd_o(s_wb_rd), .wb_data_o(s_wb_data),
        .err_o(s_err), .err_code_o(s_err_code)
    );

    // ---------------- reference model (byte-level view of the bus) ----------------
    function automatic bit m_legal(input int nbus, input int sz, input logic [31:0] a);
        int n;
        n = 1 << sz;
        return (n <= nbus) && ((a % 32'(n)) == 0);
    endfunction

    function automatic logic [7:0] m_be(input int nbus, input int sz, input logic [31:0] a);
        int n, lane;
        n = 1 << sz;
        lane = int'(a % 32'(nbus));
        m_be = '0;
        for (int b = 0; b < nbus; b++) m_be[b] = (b >= lane) && (b < lane + n);
    endfunction

    function automatic logic [63:0] m_wdata(input int nbus, input int sz, input logic [63:0] wd);
        int n;
        n = 1 << sz;
        m_wdata = '0;
        for (int b = 0; b < nbus; b++) m_wdata[8*b +: 8] = wd[8*(b % n) +: 8];
    endfunction

    function automatic logic [63:0] m_load(input int nbus, input int sz, input logic sg,
                                           input logic [31:0] a, input logic [63:0] rsp);
        int n, lane;
        logic [7:0] fill;
        n = 1 << sz;
        lane = int'(a % 32'(nbus));
        m_load = '0;
        for (int k = 0; k < n; k++) m_load[8*k +: 8] = rsp[8*(lane+k) +: 8];
        fill = (sg && m_load[8*n-1]) ? 8'hFF : 8'h00;
        for (int k = n; k < nbus; k++) m_load[8*k +: 8] = fill;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [63:0] wd, input logic [4:0] rd);
        op_valid  = 1'b1;
        op_load   = ld;
        op_store  = !ld;
        op_size   = sz;
        op_signed = sg;
        op_addr   = a;
        op_wdata  = wd;
        op_rd     = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; reset64_n = 1'b0;
        op_valid = 0; op_load = 0; op_store = 0; op_size = 0; op_signed = 0;
        op_addr = 0; op_wdata = 0; op_rd = 0; flush = 0; req_ready = 0;
        rsp_valid = 0; rsp_data = 0;
        cyc(); cyc();
        checks++;
        if ({stall, req_valid, req_we, wb_valid, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000", {stall, req_valid, req_we, wb_valid, err});
        end
        checks++;
        if ({req_addr, req_be, req_wdata, wb_data, wb_rd, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_fields got addr=%h be=%h wd=%h wb=%h rd=%0d code=%0d exp all 0",
                     req_addr, req_be, req_wdata, wb_data, wb_rd, err_code);
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_load_byte();
        drive_op(1'b1, 2'd0, 1'b1, 32'h1003, 64'h0, 5'd7);
        #1;
        checks++;
        if (stall !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL ldb_accept got stall=%b err=%b exp stall=1 err=0", stall, err);
        end
        cyc();
        req_ready = 1'b1; #1;
        checks++;
        if (req_valid !== 1'b1 || req_be !== 4'b1000 || req_addr !== 32'h1000 || req_we !== 1'b0) begin
            errors++;
            $display("FAIL ldb_req got v=%b be=%b addr=%h we=%b exp v=1 be=1000 addr=00001000 we=0",
                     req_valid, req_be, req_addr, req_we);
        end
        cyc();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 64'h80FF_FF12; #1;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL ldb_resp got wb=%b stall=%b exp wb=0 stall=1", wb_valid, stall);
        end
        cyc();
        rsp_valid = 1'b0; #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_rd !== 5'd7 || stall !== 1'b0) begin
            errors++;
            $display("FAIL ldb_done got wb=%b data=%h rd=%0d stall=%b exp wb=1 data=ffffff80 rd=7 stall=0",
                     wb_valid, wb_data, wb_rd, stall);
        end
        cyc();
        op_valid = 1'b0; #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL ldb_pulse got wb=%b exp 0", wb_valid);
        end
    endtask

    task automatic test_store_half();
        int vcnt;
        vcnt = 0;
        drive_op(1'b0, 2'd1, 1'b0, 32'h2002, 64'h0000_BEEF, 5'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (req_valid) vcnt++;
        end
        cyc();
        req_ready = 1'b1; #1;
        if (req_valid) vcnt++;
        checks++;
        if (req_be !== 4'b1100 || req_wdata !== 32'hBEEF_BEEF || req_addr !== 32'h2000 || req_we !== 1'b1) begin
            errors++;
            $display("FAIL sth_req got be=%b wd=%h addr=%h we=%b exp be=1100 wd=beefbeef addr=00002000 we=1",
                     req_be, req_wdata, req_addr, req_we);
        end
        cyc();
        req_ready = 1'b0; #1;
        checks++;
        if (stall !== 1'b0 || req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL sth_done got stall=%b v=%b wb=%b exp 0 0 0", stall, req_valid, wb_valid);
        end
        checks++;
        if (vcnt != 4) begin
            errors++; $display("FAIL sth_valid_cycles got=%0d exp=4", vcnt);
        end
        cyc();
        op_valid = 1'b0;
    endtask

    task automatic test_misaligned();
        drive_op(1'b1, 2'd2, 1'b0, 32'h3001, 64'h0, 5'd1);
        #1;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || stall !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign got err=%b code=%0d stall=%b v=%b exp err=1 code=1 stall=0 v=0",
                     err, err_code, stall, req_valid);
        end
        cyc();
        op_valid = 1'b0; #1;
        checks++;
        if (req_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL misalign_after got v=%b err=%b exp 0 0", req_valid, err);
        end
    endtask

    task automatic test_flush_drain();
        drive_op(1'b1, 2'd2, 1'b0, 32'h3000, 64'h0, 5'd3);
        #1;
        cyc();
        req_ready = 1'b1; #1;
        cyc();
        req_ready = 1'b0; flush = 1'b1; #1;
        cyc();
        flush = 1'b0; op_valid = 1'b0; #1;
        checks++;
        if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL drain_wait got stall=%b wb=%b exp 1 0", stall, wb_valid);
        end
        cyc();
        rsp_valid = 1'b1; rsp_data = 64'h1234_5678; #1;
        checks++;
        if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL drain_rsp got stall=%b wb=%b exp 1 0", stall, wb_valid);
        end
        cyc();
        rsp_valid = 1'b0;
        drive_op(1'b0, 2'd2, 1'b0, 32'h10, 64'h55, 5'd0);
        #1;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL drain_next got wb=%b stall=%b err=%b exp wb=0 stall=1 err=0", wb_valid, stall, err);
        end
        cyc();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h10) begin
            errors++; $display("FAIL drain_next_req got v=%b addr=%h exp v=1 addr=00000010", req_valid, req_addr);
        end
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0; op_valid = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        drive_op(1'b0, 2'd2, 1'b0, 32'h40, 64'hDEAD_BEEF, 5'd0);
        #1;
        cyc();
        for (int i = 1; i <= 20; i++) begin
            if (err) begin
                n = i;
                break;
            end
            cyc();
        end
        checks++;
        if (n != 8 || err_code !== 2'd2 || req_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hit got cycle=%0d code=%0d v=%b exp cycle=8 code=2 v=1", n, err_code, req_valid);
        end
        cyc();
        checks++;
        if (stall !== 1'b0 || wb_valid !== 1'b0 || req_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done got stall=%b wb=%b v=%b err=%b exp 0 0 0 0", stall, wb_valid, req_valid, err);
        end
        op_valid = 1'b0;
        cyc();
        checks++;
        if (stall !== 1'b0 || req_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got stall=%b v=%b exp 0 0", stall, req_valid);
        end
    endtask

    task automatic test_random();
        logic        ld, sg;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [63:0] wd, rsp, expd;
        logic [4:0]  rd;
        int          dly;
        for (int it = 0; it < 40; it++) begin
            ld = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            wd = {32'h0, $urandom};
            rd = 5'($urandom_range(0, 31));
            drive_op(ld, sz, sg, a, wd, rd);
            #1;
            if (!m_legal(4, int'(sz), a)) begin
                checks++;
                if (err !== 1'b1 || err_code !== 2'd1 || stall !== 1'b0 || req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_illegal it=%0d got err=%b code=%0d stall=%b exp err=1 code=1 stall=0",
                             it, err, err_code, stall);
                end
                cyc();
                op_valid = 1'b0;
                continue;
            end
            checks++;
            if (stall !== 1'b1 || err !== 1'b0) begin
                errors++; $display("FAIL rnd_accept it=%0d got stall=%b err=%b exp 1 0", it, stall, err);
            end
            cyc();
            dly = $urandom_range(0, 2);
            for (int d = 0; d < dly; d++) cyc();
            req_ready = 1'b1; #1;
            expd = m_wdata(4, int'(sz), wd);
            checks++;
            if (req_valid !== 1'b1 || req_addr !== (a & ~32'h3) || {4'h0, req_be} !== m_be(4, int'(sz), a)
                || req_we !== !ld || (!ld && req_wdata !== expd[31:0])) begin
                errors++;
                $display("FAIL rnd_req it=%0d got v=%b addr=%h be=%b wd=%h we=%b exp addr=%h be=%b wd=%h we=%b",
                         it, req_valid, req_addr, req_be, req_wdata, req_we,
                         a & ~32'h3, m_be(4, int'(sz), a), expd[31:0], !ld);
            end
            cyc();
            req_ready = 1'b0;
            if (ld) begin
                dly = $urandom_range(0, 2);
                for (int d = 0; d < dly; d++) cyc();
                rsp = {32'h0, $urandom};
                rsp_data = rsp; rsp_valid = 1'b1; #1;
                cyc();
                rsp_valid = 1'b0; #1;
                expd = m_load(4, int'(sz), sg, a, rsp);
                checks++;
                if (wb_valid !== 1'b1 || wb_data !== expd[31:0] || wb_rd !== rd || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_wb it=%0d got wb=%b data=%h rd=%0d stall=%b exp wb=1 data=%h rd=%0d stall=0",
                             it, wb_valid, wb_data, wb_rd, stall, expd[31:0], rd);
                end
            end else begin
                checks++;
                if (stall !== 1'b0 || wb_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_st_done it=%0d got stall=%b wb=%b exp 0 0", it, stall, wb_valid);
                end
            end
            cyc();
            op_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_resp();
        drive_op(1'b1, 2'd2, 1'b1, 32'h5000, 64'h0, 5'd9);
        #1;
        cyc();
        req_ready = 1'b1; #1;
        cyc();
        req_ready = 1'b0; reset_n = 1'b0; #1;
        cyc();
        op_valid = 1'b0; reset_n = 1'b1; #1;
        checks++;
        if ({stall, req_valid, wb_valid, err} !== 4'b0 || wb_data !== 32'h0 || req_be !== 4'h0
            || req_addr !== 32'h0 || wb_rd !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid got stall=%b v=%b wb=%b err=%b data=%h be=%b addr=%h rd=%0d exp all 0",
                     stall, req_valid, wb_valid, err, wb_data, req_be, req_addr, wb_rd);
        end
        rsp_valid = 1'b1; rsp_data = 64'hCAFE_F00D; #1;
        cyc();
        rsp_valid = 1'b0; #1;
        checks++;
        if (wb_valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || wb_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_stray_rsp got wb=%b stall=%b err=%b data=%h exp 0 0 0 0",
                     wb_valid, stall, err, wb_data);
        end
    endtask

    task automatic test_dword64();
        logic [1:0]  szs  [3] = '{2'd3, 2'd2, 2'd1};
        logic [31:0] adrs [3] = '{32'h8, 32'hC, 32'h6};
        logic [63:0] rsp, expd, wd;
        reset64_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            wd = {$urandom, $urandom};
            drive_op(1'b1, szs[i], 1'b1, adrs[i], wd, 5'(i + 1));
            #1;
            checks++;
            if (s_stall !== 1'b1 || s_err !== 1'b0 || s_err_code !== 2'd0) begin
                errors++;
                $display("FAIL d64_accept i=%0d got stall=%b err=%b code=%0d exp 1 0 0", i, s_stall, s_err, s_err_code);
            end
            if (i == 0) begin
                checks++;
                if (err !== 1'b1 || err_code !== 2'd1) begin
                    errors++; $display("FAIL d32_dword_illegal got err=%b code=%0d exp 1 1", err, err_code);
                end
            end
            cyc();
            req_ready = 1'b1; #1;
            expd = m_wdata(8, int'(szs[i]), wd);
            checks++;
            if (s_req_valid !== 1'b1 || s_req_be !== m_be(8, int'(szs[i]), adrs[i])
                || s_req_addr !== (adrs[i] & ~32'h7) || s_req_we !== 1'b0 || s_req_wdata !== expd) begin
                errors++;
                $display("FAIL d64_req i=%0d got v=%b be=%b addr=%h we=%b wd=%h exp be=%b addr=%h wd=%h",
                         i, s_req_valid, s_req_be, s_req_addr, s_req_we, s_req_wdata,
                         m_be(8, int'(szs[i]), adrs[i]), adrs[i] & ~32'h7, expd);
            end
            cyc();
            req_ready = 1'b0;
            rsp = {$urandom | 32'h8000_0000, $urandom | 32'h8080_8080};
            rsp_data = rsp; rsp_valid = 1'b1; #1;
            cyc();
            rsp_valid = 1'b0; #1;
            expd = m_load(8, int'(szs[i]), 1'b1, adrs[i], rsp);
            checks++;
            if (s_wb_valid !== 1'b1 || s_wb_data !== expd || s_wb_rd !== 5'(i + 1)) begin
                errors++;
                $display("FAIL d64_wb i=%0d got wb=%b data=%h rd=%0d exp wb=1 data=%h rd=%0d",
                         i, s_wb_valid, s_wb_data, s_wb_rd, expd, i + 1);
            end
            cyc();
            op_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_flush_drain();
        test_timeout();
        test_random();
        test_reset_mid_resp();
        test_dword64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
